// File: rtl/hsid_pkg.sv
// hsid_pkg -- shared constants and types for the HSID stream blocks.
//   HSID_WORD_WIDTH        : default data/address width
//   HSID_MEM_ACCESS_WIDTH  : default width of stream limit/stride/counters
//   HSID_MAX_OUTSTANDING   : default cap on granted-but-unanswered reads
//   HSID_STREAM_FIFO_DEPTH : default output buffer depth
//   hsid_x_obi_stream_state_t : stream reader FSM states
package hsid_pkg;

  localparam int HSID_WORD_WIDTH        = 32;
  localparam int HSID_MEM_ACCESS_WIDTH  = 16;
  localparam int HSID_MAX_OUTSTANDING   = 2;
  localparam int HSID_STREAM_FIFO_DEPTH = 4;

  typedef enum logic [2:0] {
    HXOS_IDLE    = 3'd0,
    HXOS_INIT    = 3'd1,
    HXOS_READING = 3'd2,
    HXOS_DRAIN   = 3'd3,
    HXOS_DONE    = 3'd4,
    HXOS_CLEAR   = 3'd5
  } hsid_x_obi_stream_state_t;

endpackage

// File: rtl/hsid_x_obi_inf_pkg.sv
// hsid_x_obi_inf_pkg -- OBI manager request / subordinate response bundles.
//   obi_req_t  : req, we, be, addr, wdata   (manager -> memory)
//   obi_resp_t : gnt, rvalid, rdata         (memory -> manager)
package hsid_x_obi_inf_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/hsid_x_stream_fifo.sv
// hsid_x_stream_fifo -- show-ahead FIFO buffering read data for the consumer.
//   clk, rst_n  : clock, synchronous active-low reset (clears pointers and storage)
//   push/push_data : write one entry (caller guarantees room)
//   pop         : remove head; ignored when empty
//   flush       : drop all contents; wins over push and pop
//   head_data/head_valid : current head (zero when empty)
//   count       : number of stored entries
module hsid_x_stream_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           head_data,
  output logic                       head_valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    do_pop   = pop && (count_q != '0) && !flush;
    do_push  = push && !flush;
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign count      = count_q;
  assign head_valid = (count_q != '0);
  // Gate the head so an empty FIFO always presents zero.
  assign head_data  = head_valid ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/hsid_x_obi_stream_reader.sv
// hsid_x_obi_stream_reader -- strided OBI read streamer with buffered output.
//   clk, rst_n      : clock, synchronous active-low reset
//   obi_req/obi_rsp : OBI manager port (read-only: we=0, be=all ones)
//   start, clear    : begin a stream / abort back to IDLE
//   initial_addr, stride, limit : first byte address, word stride, word count (0 = all ones)
//   data_out, data_out_valid, data_out_ready : valid/ready output stream
//   idle, ready, done : status (done pulses for one cycle)
// Optional: define HSID_X_OBI_STREAM_PERF_EN to add perf_stall_cycles[31:0].
module hsid_x_obi_stream_reader
  import hsid_pkg::*;
#(
  parameter int WORD_WIDTH       = HSID_WORD_WIDTH,
  parameter int MEM_ACCESS_WIDTH = HSID_MEM_ACCESS_WIDTH,
  parameter int MAX_OUTSTANDING  = HSID_MAX_OUTSTANDING,
  parameter int FIFO_DEPTH       = HSID_STREAM_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  output hsid_x_obi_inf_pkg::obi_req_t  obi_req,
  input  hsid_x_obi_inf_pkg::obi_resp_t obi_rsp,
  input  logic                          start,
  input  logic                          clear,
  input  logic [WORD_WIDTH-1:0]         initial_addr,
  input  logic [MEM_ACCESS_WIDTH-1:0]   stride,
  input  logic [MEM_ACCESS_WIDTH-1:0]   limit,
  output logic [WORD_WIDTH-1:0]         data_out,
  output logic                          data_out_valid,
  input  logic                          data_out_ready,
  output logic                          idle,
  output logic                          ready,
  output logic                          done
`ifdef HSID_X_OBI_STREAM_PERF_EN
  ,
  output logic [31:0]                   perf_stall_cycles
`endif
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  hsid_x_obi_stream_state_t state_q, state_d;
  logic [WORD_WIDTH-1:0]       addr_q, addr_d;
  logic [MEM_ACCESS_WIDTH-1:0] stride_q, stride_d, limit_q, limit_d;
  logic [MEM_ACCESS_WIDTH-1:0] requests_q, requests_d, reads_q, reads_d;
  logic [OW-1:0]               outstanding_q, outstanding_d;
  logic [CW-1:0]               fifo_count;
  logic [WORD_WIDTH-1:0]       step;
  logic req, fire, rsp_in, push, pop, flush, aborting;

  always_comb begin
    // Credit rule: a request is only issued if its response is guaranteed a
    // FIFO slot, so pushes never need back-pressure. The terms can only fall
    // while req waits for gnt, which keeps req/addr stable until granted.
    req = (state_q == HXOS_READING) && (requests_q < limit_q)
          && (32'(outstanding_q) < 32'(MAX_OUTSTANDING))
          && ((32'(fifo_count) + 32'(outstanding_q)) < 32'(FIFO_DEPTH));
    fire     = req && obi_rsp.gnt;
    rsp_in   = obi_rsp.rvalid && (outstanding_q != '0);
    aborting = clear && (state_q inside {HXOS_INIT, HXOS_READING, HXOS_DRAIN, HXOS_DONE});
    // Flush on the abort edge too, so no stale head is visible in CLEAR.
    flush    = aborting || (state_q == HXOS_CLEAR);
    push     = rsp_in && (state_q inside {HXOS_READING, HXOS_DRAIN});
    pop      = data_out_valid && data_out_ready;
    step     = WORD_WIDTH'({stride_q, 2'b00});
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    stride_d      = stride_q;
    limit_d       = limit_q;
    requests_d    = requests_q;
    reads_d       = reads_q;
    // A grant racing a response in the same cycle leaves the count unchanged.
    outstanding_d = outstanding_q + OW'(fire) - OW'(rsp_in);
    if (fire) begin
      requests_d = requests_q + MEM_ACCESS_WIDTH'(1);
      addr_d     = addr_q + step;
    end
    if (push) reads_d = reads_q + MEM_ACCESS_WIDTH'(1);

    case (state_q)
      HXOS_IDLE:    if (start && !clear) state_d = HXOS_INIT;
      HXOS_INIT: begin
        addr_d     = initial_addr;
        stride_d   = stride;
        limit_d    = (limit == '0) ? '1 : limit;
        requests_d = '0;
        reads_d    = '0;
        state_d    = HXOS_READING;
      end
      HXOS_READING: if (requests_q == limit_q) state_d = HXOS_DRAIN;
      HXOS_DRAIN:   if ((reads_q == limit_q) && (fifo_count == '0)) state_d = HXOS_DONE;
      HXOS_DONE:    state_d = HXOS_IDLE;
      HXOS_CLEAR:   if (outstanding_q == '0) state_d = HXOS_IDLE;
      default:      state_d = HXOS_IDLE;
    endcase

    // Responses still in flight are tracked by outstanding and absorbed in CLEAR.
    if (aborting) begin
      state_d    = HXOS_CLEAR;
      requests_d = '0;
      reads_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= HXOS_IDLE;
      addr_q        <= '0;
      stride_q      <= '0;
      limit_q       <= '0;
      requests_q    <= '0;
      reads_q       <= '0;
      outstanding_q <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      stride_q      <= stride_d;
      limit_q       <= limit_d;
      requests_q    <= requests_d;
      reads_q       <= reads_d;
      outstanding_q <= outstanding_d;
    end
  end

  hsid_x_stream_fifo #(
    .WIDTH (WORD_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_data  (obi_rsp.rdata),
    .pop        (pop),
    .flush      (flush),
    .head_data  (data_out),
    .head_valid (data_out_valid),
    .count      (fifo_count)
  );

  always_comb begin
    obi_req       = '0;
    obi_req.req   = req;
    obi_req.we    = 1'b0;
    obi_req.be    = '1;
    obi_req.addr  = addr_q;
  end

  assign idle  = (state_q == HXOS_IDLE);
  assign ready = (state_q == HXOS_IDLE);
  assign done  = (state_q == HXOS_DONE);

`ifdef HSID_X_OBI_STREAM_PERF_EN
  logic [31:0] perf_q, perf_d;
  logic        stall;

  always_comb begin
    stall  = (state_q inside {HXOS_READING, HXOS_DRAIN})
             && ((req && !obi_rsp.gnt) || (data_out_valid && !data_out_ready));
    perf_d = perf_q;
    if (state_q == HXOS_INIT) perf_d = '0;
    else if (stall && (perf_q != '1)) perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) perf_q <= '0;
    else        perf_q <= perf_d;
  end

  assign perf_stall_cycles = perf_q;
`endif

endmodule

// File: tb/tb_hsid_x_obi_stream_reader.sv
// Scoreboard bench: stimulus pushes expected grant addresses and data words;
// a negedge monitor (also the memory model) pops and compares.
module tb_hsid_x_obi_stream_reader;
  import hsid_x_obi_inf_pkg::*;

  localparam logic [31:0] DATA_KEY = 32'h5A5A_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  obi_req_t    obi_req;
  obi_resp_t   obi_rsp;
  logic        start = 1'b0, clear = 1'b0;
  logic [31:0] initial_addr = '0;
  logic [15:0] stride = '0, limit = '0;
  logic [31:0] data_out;
  logic        data_out_valid;
  logic        data_out_ready = 1'b1;
  logic        idle, ready, done;
`ifdef HSID_X_OBI_STREAM_PERF_EN
  logic [31:0] perf_stall_cycles;
`endif

  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  hsid_x_obi_stream_reader dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .obi_req        (obi_req),
    .obi_rsp        (obi_rsp),
    .start          (start),
    .clear          (clear),
    .initial_addr   (initial_addr),
    .stride         (stride),
    .limit          (limit),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .idle           (idle),
    .ready          (ready),
    .done           (done)
`ifdef HSID_X_OBI_STREAM_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  // Bench knobs and scoreboard state
  int          lat = 1;
  bit          gnt_throttle = 0;
  bit          cap_check = 0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [31:0] pend_addr_q[$];
  int          pend_due_q[$];
  int          cyc = 0, tot_gr = 0, tot_rv = 0, done_cnt = 0, pops = 0;
  logic        prev_req = 0, prev_gnt = 0, prev_clear = 0, prev_valid = 0, prev_ready = 0;
  logic [31:0] prev_addr = 0, prev_data = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  task automatic push_exp(input logic [31:0] a);
    exp_addr_q.push_back(a);
    exp_data_q.push_back(a ^ DATA_KEY);
  endtask

  task automatic flush_exp();
    exp_addr_q.delete();
    exp_data_q.delete();
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic start_stream(input logic [31:0] a, input logic [15:0] s, input logic [15:0] l);
    initial_addr = a;
    stride       = s;
    limit        = l;
    start        = 1'b1;
    cycle();
    start        = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int base;
    int k;
    base = done_cnt;
    k = 0;
    while (done_cnt == base && k < 400) begin
      cycle();
      k++;
    end
    check(name, 32'(done_cnt != base), 1);
  endtask

  task automatic wait_grants(input int g0, input int n);
    int k;
    k = 0;
    while ((tot_gr - g0) < n && k < 100) begin
      cycle();
      k++;
    end
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (!idle && k < 100) begin
      cycle();
      k++;
    end
    check(name, 32'(idle), 1);
  endtask

  // Monitor + memory model, all on the negedge, away from the DUT edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend_addr_q.delete();
      pend_due_q.delete();
      tot_rv     = tot_gr;
      obi_rsp    = '0;
      prev_req   = 0;
      prev_gnt   = 0;
      prev_clear = 0;
      prev_valid = 0;
      prev_ready = 0;
    end else begin
      cyc++;
      if (prev_req && !prev_gnt && !prev_clear) begin
        check("req_hold", 32'(obi_req.req), 1);
        check("addr_hold", obi_req.addr, prev_addr);
      end
      if (prev_valid && !prev_ready && !prev_clear) begin
        check("valid_hold", 32'(data_out_valid), 1);
        check("data_hold", data_out, prev_data);
      end
      if (cap_check) begin
        check("outstanding_cap", 32'((tot_gr - tot_rv) <= 2), 1);
        if ((tot_gr - tot_rv) >= 2) check("req_low_at_cap", 32'(obi_req.req), 0);
      end
      if (done) done_cnt++;

      if (data_out_valid && data_out_ready) begin
        pops++;
        tests++;
        if (exp_data_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_data: got %h expected no output", data_out);
        end else begin
          logic [31:0] e;
          e = exp_data_q.pop_front();
          $display("[TB] data %h expected %h", data_out, e);
          if (data_out !== e) begin
            fails++;
            $display("FAIL data_out: got %h expected %h", data_out, e);
          end
        end
      end

      obi_rsp.rvalid = 1'b0;
      obi_rsp.rdata  = '0;
      if (pend_due_q.size() != 0 && pend_due_q[0] <= cyc) begin
        obi_rsp.rvalid = 1'b1;
        obi_rsp.rdata  = pend_addr_q.pop_front() ^ DATA_KEY;
        void'(pend_due_q.pop_front());
        tot_rv++;
      end
      obi_rsp.gnt = gnt_throttle ? ((cyc % 3) == 0) : 1'b1;
      if (obi_req.req && obi_rsp.gnt) begin
        tests++;
        if (exp_addr_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_grant: got addr %h expected no grant", obi_req.addr);
        end else begin
          logic [31:0] e;
          e = exp_addr_q.pop_front();
          $display("[TB] grant addr %h expected %h", obi_req.addr, e);
          if (obi_req.addr !== e) begin
            fails++;
            $display("FAIL grant_addr: got %h expected %h", obi_req.addr, e);
          end
        end
        check("grant_we_be", {27'd0, obi_req.we, obi_req.be}, 32'h0F);
        pend_addr_q.push_back(obi_req.addr);
        pend_due_q.push_back(cyc + lat);
        tot_gr++;
      end
      prev_req   = obi_req.req;
      prev_gnt   = obi_rsp.gnt;
      prev_clear = clear;
      prev_valid = data_out_valid;
      prev_ready = data_out_ready;
      prev_addr  = obi_req.addr;
      prev_data  = data_out;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0, d0, p0;
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    check("rst_req", 32'(obi_req.req), 0);
    check("rst_addr", obi_req.addr, 0);
    check("rst_valid", 32'(data_out_valid), 0);
    check("rst_data", data_out, 0);
    check("rst_done", 32'(done), 0);
    check("rst_idle", 32'(idle), 1);
    check("rst_ready", 32'(ready), 1);
    rst_n = 1'b1;
    cycle();

    // Basic stream, stride 1
    lat = 1;
    push_exp(32'h100); push_exp(32'h104); push_exp(32'h108); push_exp(32'h10C);
    d0 = done_cnt;
    start_stream(32'h100, 16'd1, 16'd4);
    check("init_idle", 32'(idle), 0);
    check("init_ready", 32'(ready), 0);
    wait_done("t1_done");
    repeat (3) cycle();
    check("t1_done_pulses", done_cnt - d0, 1);
    check("t1_addr_left", exp_addr_q.size(), 0);
    check("t1_data_left", exp_data_q.size(), 0);
    check("t1_idle", 32'(idle), 1);

    // Stride 3
    push_exp(32'h0); push_exp(32'hC); push_exp(32'h18);
    start_stream(32'h0, 16'd3, 16'd3);
    wait_done("t2_done");
    repeat (3) cycle();
    check("t2_addr_left", exp_addr_q.size(), 0);
    check("t2_data_left", exp_data_q.size(), 0);

    // Slow memory, throttled grants: outstanding cap and request stability
    lat = 5; gnt_throttle = 1; cap_check = 1;
    push_exp(32'h2000); push_exp(32'h2008); push_exp(32'h2010);
    push_exp(32'h2018); push_exp(32'h2020); push_exp(32'h2028);
    start_stream(32'h2000, 16'd2, 16'd6);
    wait_done("t3_done");
    repeat (3) cycle();
    gnt_throttle = 0; cap_check = 0;
    check("t3_addr_left", exp_addr_q.size(), 0);
    check("t3_data_left", exp_data_q.size(), 0);

    // Back-pressure: FIFO credit limits grants to its depth
    lat = 1;
    data_out_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_exp(32'h400 + 32'(4 * i));
    g0 = tot_gr;
    start_stream(32'h400, 16'd1, 16'd8);
    repeat (20) cycle();
    check("bp_grants", tot_gr - g0, 4);
    check("bp_valid", 32'(data_out_valid), 1);
    check("bp_head", data_out, 32'h400 ^ DATA_KEY);
    data_out_ready = 1'b1;
    wait_done("t4_done");
    repeat (3) cycle();
    check("t4_addr_left", exp_addr_q.size(), 0);
    check("t4_data_left", exp_data_q.size(), 0);

    // Clear with two reads in flight
    lat = 5;
    for (int i = 0; i < 8; i++) push_exp(32'h600 + 32'(4 * i));
    g0 = tot_gr;
    d0 = done_cnt;
    start_stream(32'h600, 16'd1, 16'd8);
    wait_grants(g0, 2);
    check("clr_setup_grants", tot_gr - g0, 2);
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    flush_exp();
    check("clr_idle", 32'(idle), 0);
    check("clr_ready", 32'(ready), 0);
    check("clr_done", 32'(done), 0);
    check("clr_valid", 32'(data_out_valid), 0);
    wait_idle("clr_back_idle");
    check("clr_absorbed", pend_addr_q.size(), 0);
    check("clr_no_done", done_cnt - d0, 0);
    // Counters must restart from zero after CLEAR
    lat = 1;
    push_exp(32'h800); push_exp(32'h804);
    start_stream(32'h800, 16'd1, 16'd2);
    wait_done("t5b_done");
    repeat (3) cycle();
    check("t5b_addr_left", exp_addr_q.size(), 0);
    check("t5b_data_left", exp_data_q.size(), 0);

    // limit = 0 streams as all-ones
    for (int i = 0; i < 40; i++) push_exp(32'h3000 + 32'(4 * i));
    p0 = pops;
    d0 = done_cnt;
    start_stream(32'h3000, 16'd1, 16'd0);
    for (int k = 0; k < 100 && (pops - p0) < 10; k++) cycle();
    check("lim0_reads", 32'((pops - p0) >= 10), 1);
    check("lim0_no_done", done_cnt - d0, 0);
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    wait_idle("lim0_back_idle");
    flush_exp();

    // start together with clear in IDLE is ignored
    g0 = tot_gr;
    start = 1'b1;
    clear = 1'b1;
    cycle();
    start = 1'b0;
    clear = 1'b0;
    check("stclr_idle", 32'(idle), 1);
    repeat (5) cycle();
    check("stclr_no_grant", tot_gr - g0, 0);
    check("stclr_idle_later", 32'(idle), 1);

    // Reset mid-stream drops outstanding reads
    lat = 5;
    for (int i = 0; i < 4; i++) push_exp(32'hA00 + 32'(4 * i));
    g0 = tot_gr;
    start_stream(32'hA00, 16'd1, 16'd4);
    wait_grants(g0, 2);
    rst_n = 1'b0;
    cycle();
    check("mrst_idle", 32'(idle), 1);
    check("mrst_req", 32'(obi_req.req), 0);
    check("mrst_addr", obi_req.addr, 0);
    check("mrst_valid", 32'(data_out_valid), 0);
    rst_n = 1'b1;
    flush_exp();
    cycle();
    lat = 1;
    push_exp(32'hB00); push_exp(32'hB04); push_exp(32'hB08);
    start_stream(32'hB00, 16'd1, 16'd3);
    wait_done("t8_done");
    repeat (3) cycle();
    check("t8_addr_left", exp_addr_q.size(), 0);
    check("t8_data_left", exp_data_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
